// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and saturating-increment helper for the timeout timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // Callers widen to 32 bits and narrow the result back to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] cnt_max);
    return (cnt >= cnt_max) ? cnt_max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one qualify/timeout channel: counter, FSM, level and pulse outputs (capture under TIMER_CAPTURE_EN)
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ti,
  input  logic [CNT_W-1:0] thresh,
  output logic             to,
  output logic             to_pulse
`ifdef TIMER_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] cap
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  state_t           state;

  always_comb begin
    cnt_n = '0;
    if (ti) cnt_n = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
  end

  // Next state is judged on the updated count against the threshold in force this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      state    <= ST_IDLE;
      to_pulse <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      to_pulse <= 1'b0;
      if (!ti) begin
        state <= ST_IDLE;
      end else if (cnt_n >= thresh) begin
        state    <= ST_EXPIRED;
        to_pulse <= (state != ST_EXPIRED);
      end else begin
        state <= ST_COUNT;
      end
    end
  end

  assign to = (cnt >= thresh);

`ifdef TIMER_CAPTURE_EN
  logic ti_q;

  // On a falling edge cnt still holds the length of the run that just ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      ti_q <= 1'b0;
      cap  <= '0;
    end else begin
      ti_q <= ti;
      if (ti_q && !ti) cap <= cnt;
    end
  end
`endif

endmodule

// File: rtl/multi_ch_timeout_timer.sv
// rtl/multi_ch_timeout_timer.sv - N-channel timeout timer top: threshold bank, channels, readback (TIMER_CAPTURE_EN)
module multi_ch_timeout_timer
  import timer_pkg::*;
#(
  parameter int                      NUM_CH      = 5,
  parameter int                      CNT_W       = 13,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_THRESH = {13'd7998, 13'd192, 13'd0, 13'd62, 13'd193}
) (
  input  logic                      S_AXIS_ACLK,
  input  logic                      S_AXIS_ARESET,
  input  logic [NUM_CH-1:0]         ti,
  input  logic                      cfg_wr_en,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_thresh,
  output logic [NUM_CH-1:0]         to,
  output logic [NUM_CH-1:0]         to_pulse,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [CNT_W-1:0]          rd_cnt
);

  logic [NUM_CH-1:0][CNT_W-1:0] thresh;

  // Reset wins over a same-cycle write, so a pending write is simply dropped.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      thresh <= INIT_THRESH;
    end else if (cfg_wr_en && (32'(cfg_ch) < NUM_CH)) begin
      thresh[cfg_ch] <= cfg_thresh;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cap;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (S_AXIS_ACLK),
      .rst     (S_AXIS_ARESET),
      .ti      (ti[i]),
      .thresh  (thresh[i]),
      .to      (to[i]),
      .to_pulse(to_pulse[i])
`ifdef TIMER_CAPTURE_EN
      ,
      .cap     (cap[i])
`endif
    );
  end

`ifdef TIMER_CAPTURE_EN
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= (32'(rd_ch) < NUM_CH) ? cap[rd_ch] : '0;
    end
  end
`else
  logic unused_rd_ch;
  assign unused_rd_ch = ^rd_ch;
  assign rd_cnt       = '0;
`endif

endmodule
